ws2822_program_sequencer: RTL and testbench



---
 rtl/ws2822_program_sequencer_pkg.sv | 39 +++
 rtl/ws2822_program_sequencer_if.sv | 22 ++
 rtl/ws2822_program_sequencer_dmx_byte_tx.sv | 53 +++++
 rtl/ws2822_program_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ws2822_program_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/ws2822_program_sequencer_pkg.sv
// Shared types and constants for the WS2822 address-programming sequencer.
// FSM states, DMX frame geometry, address limit and programming-frame byte builder.
package ws2822_prog_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_PWR_ON   = 4'd1,
      ST_DATA_LOW = 4'd2,
      ST_BREAK    = 4'd3,
      ST_MAB      = 4'd4,
      ST_TX       = 4'd5,
      ST_HOLD     = 4'd6,
      ST_PWR_OFF  = 4'd7,
      ST_PWR_ON2  = 4'd8,
      ST_DONE     = 4'd9
   } state_e;

   localparam logic [7:0]  PKG_START_CODE = 8'hA0;
   localparam int unsigned FRAME_BYTES    = 3;
   localparam int unsigned BITS_PER_BYTE  = 11;
   localparam int unsigned ADDR_MAX       = 512;

   // A zero-length phase still lasts one cycle: timers count N-1 down to 0.
   function automatic int unsigned load_val(input int unsigned n);
      return (n == 0) ? 0 : n - 1;
   endfunction

   // Byte 2 carries the inverted upper address bits in its low nibble.
   function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                             input logic [11:0] addr,
                                             input logic [7:0]  start_code);
      case (idx)
         2'd0:    return start_code;
         2'd1:    return addr[7:0];
         default: return {4'hF, ~addr[11:8]};
      endcase
   endfunction

endpackage

// File: rtl/ws2822_program_sequencer_if.sv
// Host/fixture signal bundle for the WS2822 programming sequencer.
// master = host register block side, slave = sequencer side.
interface ws2822_program_sequencer_if;
   logic [15:0] address;
   logic        program_strobe;
   logic        busy;
   logic        done;
   logic        error;
   logic        power_en;
   logic        data_pin;
   logic        address_pin;

   modport master (
      output address, program_strobe,
      input  busy, done, error, power_en, data_pin, address_pin
   );

   modport slave (
      input  address, program_strobe,
      output busy, done, error, power_en, data_pin, address_pin
   );
endinterface

// File: rtl/ws2822_program_sequencer_dmx_byte_tx.sv
// DMX byte serializer: start bit, 8 data bits LSB first, two stop bits.
// ready also rises in the final cycle of the last stop bit so bytes chain gap-free.
module dmx_byte_tx
   import ws2822_prog_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam logic [15:0] BIT_LD   = 16'(load_val(BIT_CYCLES));
   localparam logic [3:0]  LAST_BIT = 4'(BITS_PER_BYTE - 1);

   logic        r_busy;
   logic [10:0] r_shift;
   logic [15:0] r_cyc;
   logic [3:0]  r_bit;
   logic        w_last;

   assign w_last = r_busy && (r_cyc == 16'd0) && (r_bit == LAST_BIT);
   assign ready  = !r_busy || w_last;
   assign tx     = r_busy ? r_shift[0] : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_shift <= '1;
         r_cyc   <= '0;
         r_bit   <= '0;
      end else if (start && ready) begin
         r_busy  <= 1'b1;
         r_shift <= {2'b11, data, 1'b0};
         r_cyc   <= BIT_LD;
         r_bit   <= '0;
      end else if (r_busy) begin
         if (r_cyc != 16'd0) begin
            r_cyc <= r_cyc - 16'd1;
         end else if (w_last) begin
            r_busy <= 1'b0;
         end else begin
            r_shift <= {1'b1, r_shift[10:1]};
            r_bit   <= r_bit + 4'd1;
            r_cyc   <= BIT_LD;
         end
      end
   end

endmodule

// File: rtl/ws2822_program_sequencer.sv
// WS2822 address-programming sequencer: power on, data low, DMX frame, hold, power cycle.
// Optional macro WS2822_PROG_REPEAT_EN repeats BREAK/MAB/frame FRAME_REPEATS times.
module ws2822_program_sequencer
   import ws2822_prog_pkg::*;
#(
   parameter int unsigned BIT_CYCLES      = 48,
   parameter int unsigned BREAK_CYCLES    = 2112,
   parameter int unsigned MAB_CYCLES      = 144,
   parameter int unsigned SETTLE_CYCLES   = 1200000,
   parameter int unsigned DATA_LOW_CYCLES = 120000,
   parameter int unsigned HOLD_CYCLES     = 600000,
   parameter int unsigned OFF_CYCLES      = 1200000,
`ifdef WS2822_PROG_REPEAT_EN
   parameter int unsigned FRAME_REPEATS   = 3,
`endif
   parameter logic [7:0]  START_CODE      = PKG_START_CODE,
   parameter int unsigned CNT_W           = 24
) (
   input logic                       clk,
   input logic                       rst_n,
   ws2822_program_sequencer_if.slave bus
);

   localparam logic [3:0] S_IDLE     = 4'(ST_IDLE);
   localparam logic [3:0] S_PWR_ON   = 4'(ST_PWR_ON);
   localparam logic [3:0] S_DATA_LOW = 4'(ST_DATA_LOW);
   localparam logic [3:0] S_BREAK    = 4'(ST_BREAK);
   localparam logic [3:0] S_MAB      = 4'(ST_MAB);
   localparam logic [3:0] S_TX       = 4'(ST_TX);
   localparam logic [3:0] S_HOLD     = 4'(ST_HOLD);
   localparam logic [3:0] S_PWR_OFF  = 4'(ST_PWR_OFF);
   localparam logic [3:0] S_PWR_ON2  = 4'(ST_PWR_ON2);
   localparam logic [3:0] S_DONE     = 4'(ST_DONE);

   localparam logic [CNT_W-1:0] T_SETTLE = CNT_W'(load_val(SETTLE_CYCLES));
   localparam logic [CNT_W-1:0] T_DLOW   = CNT_W'(load_val(DATA_LOW_CYCLES));
   localparam logic [CNT_W-1:0] T_BREAK  = CNT_W'(load_val(BREAK_CYCLES));
   localparam logic [CNT_W-1:0] T_MAB    = CNT_W'(load_val(MAB_CYCLES));
   localparam logic [CNT_W-1:0] T_HOLD   = CNT_W'(load_val(HOLD_CYCLES));
   localparam logic [CNT_W-1:0] T_OFF    = CNT_W'(load_val(OFF_CYCLES));
   localparam logic [1:0]       N_BYTES  = 2'(FRAME_BYTES);

   logic [3:0]       r_state;
   logic [CNT_W-1:0] r_timer;
   logic [1:0]       r_byte_idx;
   logic [11:0]      r_addr;
   logic             r_error;
   logic             r_pwr_keep;

   logic             w_tmo;
   logic             w_addr_ok;
   logic             w_ready;
   logic             w_tx;
   logic             w_tx_start;
   logic             w_tx_done;
   logic             w_last_frame;
   logic [7:0]       w_byte;

`ifdef WS2822_PROG_REPEAT_EN
   localparam logic [7:0] LAST_REP = 8'(load_val(FRAME_REPEATS));
   logic [7:0] r_rep;
   assign w_last_frame = (r_rep == LAST_REP);
`else
   assign w_last_frame = 1'b1;
`endif

   assign w_tmo     = (r_timer == '0);
   assign w_addr_ok = (bus.address != 16'd0) && (bus.address <= 16'(ADDR_MAX));
   assign w_byte    = frame_byte(r_byte_idx, r_addr, START_CODE);

   // First byte is launched in the last MAB cycle so TX opens directly on the start bit.
   assign w_tx_start = w_ready && (r_byte_idx != N_BYTES) &&
                       (((r_state == S_MAB) && w_tmo) || (r_state == S_TX));
   assign w_tx_done  = (r_state == S_TX) && (r_byte_idx == N_BYTES) && w_ready;

   dmx_byte_tx #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_tx_start),
      .data  (w_byte),
      .tx    (w_tx),
      .ready (w_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_byte_idx <= '0;
         r_addr     <= '0;
         r_error    <= 1'b0;
         r_pwr_keep <= 1'b0;
`ifdef WS2822_PROG_REPEAT_EN
         r_rep      <= '0;
`endif
      end else begin
         r_error <= 1'b0;
         if (!w_tmo)
            r_timer <= r_timer - 1'b1;
         if (w_tx_start)
            r_byte_idx <= r_byte_idx + 2'd1;
         case (r_state)
            S_IDLE:
               if (bus.program_strobe) begin
                  if (w_addr_ok) begin
                     r_state <= S_PWR_ON;
                     r_timer <= T_SETTLE;
                     r_addr  <= bus.address[11:0];
`ifdef WS2822_PROG_REPEAT_EN
                     r_rep   <= '0;
`endif
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            S_PWR_ON:
               if (w_tmo) begin
                  r_state <= S_DATA_LOW;
                  r_timer <= T_DLOW;
               end
            S_DATA_LOW:
               if (w_tmo) begin
                  r_state    <= S_BREAK;
                  r_timer    <= T_BREAK;
                  r_byte_idx <= '0;
               end
            S_BREAK:
               if (w_tmo) begin
                  r_state <= S_MAB;
                  r_timer <= T_MAB;
               end
            S_MAB:
               if (w_tmo)
                  r_state <= S_TX;
            S_TX:
               if (w_tx_done) begin
                  if (w_last_frame) begin
                     r_state <= S_HOLD;
                     r_timer <= T_HOLD;
                  end else begin
                     r_state    <= S_BREAK;
                     r_timer    <= T_BREAK;
                     r_byte_idx <= '0;
`ifdef WS2822_PROG_REPEAT_EN
                     r_rep      <= r_rep + 8'd1;
`endif
                  end
               end
            S_HOLD:
               if (w_tmo) begin
                  r_state <= S_PWR_OFF;
                  r_timer <= T_OFF;
               end
            S_PWR_OFF:
               if (w_tmo) begin
                  r_state <= S_PWR_ON2;
                  r_timer <= T_SETTLE;
               end
            S_PWR_ON2:
               if (w_tmo)
                  r_state <= S_DONE;
            S_DONE: begin
               r_state    <= S_IDLE;
               r_pwr_keep <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pin levels are decoded from state so an async reset drops them at once.
   always_comb begin
      bus.power_en    = 1'b0;
      bus.data_pin    = 1'b0;
      bus.address_pin = 1'b0;
      case (r_state)
         S_IDLE:     bus.power_en = r_pwr_keep;
         S_PWR_ON:   bus.power_en = 1'b1;
         S_DATA_LOW: begin bus.power_en = 1'b1; bus.address_pin = 1'b1; end
         S_BREAK:    begin bus.power_en = 1'b1; bus.address_pin = 1'b1; end
         S_MAB:      begin bus.power_en = 1'b1; bus.address_pin = 1'b1; bus.data_pin = 1'b1; end
         S_TX:       begin bus.power_en = 1'b1; bus.address_pin = 1'b1; bus.data_pin = w_tx; end
         S_HOLD:     begin bus.power_en = 1'b1; bus.address_pin = 1'b1; bus.data_pin = 1'b1; end
         S_PWR_ON2:  bus.power_en = 1'b1;
         S_DONE:     bus.power_en = 1'b1;
         default:    bus.power_en = 1'b0;
      endcase
   end

   assign bus.busy  = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done  = (r_state == S_DONE);
   assign bus.error = r_error;

endmodule

// File: tb/tb_ws2822_program_sequencer.sv
// Bench for ws2822_program_sequencer: per-cycle pin/status comparison against a
// waveform built from the phase durations and DMX byte format.
module tb_ws2822_program_sequencer;

   localparam int BITC  = 4;
   localparam int BRKC  = 10;
   localparam int MABC  = 3;
   localparam int SETC  = 20;
   localparam int DLOWC = 20;
   localparam int HOLDC = 20;
   localparam int OFFC  = 20;
`ifdef WS2822_PROG_REPEAT_EN
   localparam int REPS = 3;
`else
   localparam int REPS = 1;
`endif
   localparam int HOLD_START = SETC + DLOWC + REPS * (BRKC + MABC + 33 * BITC);

   // {busy, done, error, power_en, data_pin, address_pin}
   typedef logic [5:0] vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic m_pwr_idle = 1'b0;
   vec_t q[$];

   always #5 clk = ~clk;

   ws2822_program_sequencer_if u_if ();

   ws2822_program_sequencer #(
      .BIT_CYCLES      (BITC),
      .BREAK_CYCLES    (BRKC),
      .MAB_CYCLES      (MABC),
      .SETTLE_CYCLES   (SETC),
      .DATA_LOW_CYCLES (DLOWC),
      .HOLD_CYCLES     (HOLDC),
      .OFF_CYCLES      (OFFC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   function automatic vec_t obs();
      return {u_if.busy, u_if.done, u_if.error, u_if.power_en, u_if.data_pin, u_if.address_pin};
   endfunction

   task automatic check(input string tag, input vec_t exp);
      vec_t o;
      o = obs();
      n_cmp++;
      assert (o === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, o, exp);
      end
   endtask

   task automatic push(input int n, input vec_t v);
      for (int k = 0; k < n; k++) q.push_back(v);
   endtask

   // Expected per-cycle waveform for one accepted request, starting the cycle after the strobe.
   task automatic build(input logic [15:0] a);
      logic [7:0] bytes [3];
      logic       b;
      bytes[0] = 8'hA0;
      bytes[1] = a[7:0];
      bytes[2] = {4'hF, ~a[11:8]};
      q.delete();
      push(SETC,  6'b100100);
      push(DLOWC, 6'b100101);
      for (int r = 0; r < REPS; r++) begin
         push(BRKC, 6'b100101);
         push(MABC, 6'b100111);
         for (int by = 0; by < 3; by++)
            for (int k = 0; k < 11; k++) begin
               if (k == 0)      b = 1'b0;
               else if (k <= 8) b = bytes[by][k-1];
               else             b = 1'b1;
               push(BITC, {4'b1001, b, 1'b1});
            end
      end
      push(HOLDC, 6'b100111);
      push(OFFC,  6'b100000);
      push(SETC,  6'b100100);
      push(1,     6'b010100);
      push(1,     6'b000100);
   endtask

   task automatic run(input logic [15:0] a, input bit noise, input int abort_at);
      build(a);
      @(negedge clk);
      u_if.address = a;
      u_if.program_strobe = 1'b1;
      @(negedge clk);
      u_if.program_strobe = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            check($sformatf("async_rst_a%0h", a), 6'b000000);
            @(negedge clk);
            u_if.program_strobe = 1'b0;
            u_if.address = a;
            rst_n = 1'b1;
            m_pwr_idle = 1'b0;
            return;
         end
         check($sformatf("seq_a%0h_c%0d", a, i), q[i]);
         if (noise && i < q.size() - 1) begin
            u_if.program_strobe = 1'($urandom_range(0, 1));
            u_if.address = 16'($urandom);
         end else begin
            u_if.program_strobe = 1'b0;
            u_if.address = a;
         end
         @(negedge clk);
      end
      m_pwr_idle = 1'b1;
   endtask

   task automatic reject(input logic [15:0] a);
      @(negedge clk);
      u_if.address = a;
      u_if.program_strobe = 1'b1;
      @(negedge clk);
      u_if.program_strobe = 1'b0;
      check($sformatf("err_pulse_a%0h", a), {3'b001, m_pwr_idle, 2'b00});
      @(negedge clk);
      check($sformatf("err_clear_a%0h", a), {3'b000, m_pwr_idle, 2'b00});
   endtask

   initial begin
      u_if.address = 16'd0;
      u_if.program_strobe = 1'b0;
      #12;
      check("reset_state", 6'b000000);
      @(negedge clk);
      rst_n = 1'b1;

      reject(16'd0);
      run(16'h0001, 1'b0, -1);
      run(16'h01FF, 1'b0, -1);
      reject(16'd0);
      reject(16'd513);
      reject(16'($urandom_range(513, 65535)));
      run(16'($urandom_range(1, 512)), 1'b1, -1);
      run(16'($urandom_range(1, 512)), 1'b1, HOLD_START + 5);
      reject(16'd0);
      run(16'($urandom_range(1, 512)), 1'b1, -1);
      for (int t = 0; t < 3; t++)
         run(16'($urandom_range(1, 512)), 1'b1, -1);
      run(16'd512, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
